// File: rtl/seq_restoring_divider.sv
// Sequential radix-2 restoring divider.
// Takes an N/3-bit dividend and an N/6-bit divisor and produces one quotient
// bit per clock, MSB first. A zero divisor short-circuits straight to FIN
// with an all-ones quotient, the low dividend bits as remainder, and the
// div_by_zero flag set.
`timescale 1ns/1ps

module seq_restoring_divider #(
    parameter int N = 222
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N/3-1:0]       dividend,
    input  logic [N/6-1:0]       divisor,
    output logic                 busy,
    output logic                 done,
    output logic [N/3-1:0]       quotient,
    output logic [N/6-1:0]       remainder,
    output logic                 div_by_zero
);

    localparam int QW = N / 3;
    localparam int RW = N / 6;
    localparam int CW = $clog2(QW + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [QW-1:0]   dsr_q, dsr_d;      // dividend shift register, MSB consumed first
    logic [RW-1:0]   dvs_q, dvs_d;      // divisor captured at accept
    logic [RW-1:0]   prem_q, prem_d;    // partial remainder (always < divisor between steps)
    logic [CW-1:0]   cnt_q, cnt_d;      // iterations still to perform
    logic [QW-1:0]   quo_q, quo_d;      // quotient, bits shifted in at the LSB
    logic [RW-1:0]   rem_q, rem_d;      // published remainder
    logic            dz_q, dz_d;        // published divide-by-zero flag

    // One restoring step. The shifted partial remainder needs RW+1 bits;
    // after a successful subtract the result is below the divisor, so the
    // subtraction can be done modulo 2^RW without losing information.
    logic [RW:0]     p_shift;
    logic [RW:0]     dvs_ext;
    logic            q_bit;
    logic [RW-1:0]   p_diff;
    logic [RW-1:0]   p_step;

    // Trial subtraction and restore selection for the current iteration
    always_comb begin
        p_shift = {prem_q, dsr_q[QW-1]};
        dvs_ext = {1'b0, dvs_q};
        q_bit   = (p_shift >= dvs_ext);
        p_diff  = p_shift[RW-1:0] - dvs_q;
        p_step  = q_bit ? p_diff : p_shift[RW-1:0];
    end

    // Next-state and datapath update; FIN behaves like IDLE for new requests
    always_comb begin
        state_d = state_q;
        dsr_d   = dsr_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE, S_FIN: begin
                if (start) begin
                    dsr_d  = dividend;
                    dvs_d  = divisor;
                    prem_d = '0;
                    cnt_d  = CW'(QW);
                    if (divisor == '0) begin
                        state_d = S_FIN;
                        quo_d   = '1;
                        rem_d   = dividend[RW-1:0];
                        dz_d    = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        quo_d   = '0;
                        rem_d   = '0;
                        dz_d    = 1'b0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                prem_d = p_step;
                dsr_d  = {dsr_q[QW-2:0], 1'b0};
                quo_d  = {quo_q[QW-2:0], q_bit};
                cnt_d  = cnt_q - CW'(1);
                // The final iteration publishes the remainder and hands over to FIN
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIN;
                    rem_d   = p_step;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dsr_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            dsr_q   <= dsr_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    // Status outputs decode directly from the registered state
    always_comb begin
        busy        = (state_q == S_RUN);
        done        = (state_q == S_FIN);
        quotient    = quo_q;
        remainder   = rem_q;
        div_by_zero = dz_q;
    end

endmodule
